// File: rtl/execute_stage_if.sv
// ID/EX operand/control bundle, WB forwarding inputs and EX/MEM results of the execute stage.
// The pipeline side drives the master modport; execute_stage is the slave.
interface execute_stage_if #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  // ID/EX register contents
  logic                  RegWrite_E;
  logic                  ALUSrc_E;
  logic                  MemWrite_E;
  logic                  MemRead_E;
  logic                  Branch_E;
  logic                  MemtoReg_E;
  logic [3:0]            control_o_E;
  logic [DAT_WIDTH-1:0]  ImmExt_E;
  logic [DAT_WIDTH-1:0]  rdata1_E;
  logic [DAT_WIDTH-1:0]  rdata2_E;
  logic [4:0]            rs1_E;
  logic [4:0]            rs2_E;
  logic [4:0]            rd_E;
  logic [ADDR_WIDTH-1:0] PC_E;
  logic [ADDR_WIDTH-1:0] PC_4E;

  // writeback-stage forwarding source
  logic                  RegWrite_W;
  logic [4:0]            rd_W;
  logic [DAT_WIDTH-1:0]  Result_W;

  // branch resolution (combinational)
  logic                  PCSrc_E;
  logic [ADDR_WIDTH-1:0] PC_Target_E;

  // EX/MEM register contents
  logic                  RegWrite_M;
  logic                  MemWrite_M;
  logic                  MemRead_M;
  logic                  MemtoReg_M;
  logic [DAT_WIDTH-1:0]  ALUResult_M;
  logic [DAT_WIDTH-1:0]  WriteData_M;
  logic [4:0]            rd_M;
  logic [ADDR_WIDTH-1:0] PC_4M;

  modport master (
    output RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E,
    output control_o_E, ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E,
    output RegWrite_W, rd_W, Result_W,
    input  PCSrc_E, PC_Target_E,
    input  RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M,
    input  ALUResult_M, WriteData_M, rd_M, PC_4M
  );

  modport slave (
    input  RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E,
    input  control_o_E, ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E,
    input  RegWrite_W, rd_W, Result_W,
    output PCSrc_E, PC_Target_E,
    output RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M,
    output ALUResult_M, WriteData_M, rd_M, PC_4M
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: MEM/WB operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// The EX/MEM register captures on every edge; stalls and squashes are handled upstream.
module execute_stage #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  execute_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  logic                  r_regwrite_m;
  logic                  r_memwrite_m;
  logic                  r_memread_m;
  logic                  r_memtoreg_m;
  logic [DAT_WIDTH-1:0]  r_alu_result_m;
  logic [DAT_WIDTH-1:0]  r_write_data_m;
  logic [4:0]            r_rd_m;
  logic [ADDR_WIDTH-1:0] r_pc_4m;

  logic                  w_fwd_a_mem;
  logic                  w_fwd_a_wb;
  logic                  w_fwd_b_mem;
  logic                  w_fwd_b_wb;
  logic [DAT_WIDTH-1:0]  w_src_a;
  logic [DAT_WIDTH-1:0]  w_fwd_b;
  logic [DAT_WIDTH-1:0]  w_src_b;
  logic [DAT_WIDTH-1:0]  w_alu_result;
  logic                  w_zero;
  logic [ADDR_WIDTH-1:0] w_imm_addr;

  // x0 is hard-wired to zero, so a pending write to it must never be forwarded.
  assign w_fwd_a_mem = r_regwrite_m   && (r_rd_m   != 5'd0) && (r_rd_m   == bus.rs1_E);
  assign w_fwd_a_wb  = bus.RegWrite_W && (bus.rd_W != 5'd0) && (bus.rd_W == bus.rs1_E);
  assign w_fwd_b_mem = r_regwrite_m   && (r_rd_m   != 5'd0) && (r_rd_m   == bus.rs2_E);
  assign w_fwd_b_wb  = bus.RegWrite_W && (bus.rd_W != 5'd0) && (bus.rd_W == bus.rs2_E);

  // MEM holds the younger result, so it is checked before WB.
  assign w_src_a = w_fwd_a_mem ? r_alu_result_m :
                   w_fwd_a_wb  ? bus.Result_W   : bus.rdata1_E;
  assign w_fwd_b = w_fwd_b_mem ? r_alu_result_m :
                   w_fwd_b_wb  ? bus.Result_W   : bus.rdata2_E;
  assign w_src_b = bus.ALUSrc_E ? bus.ImmExt_E : w_fwd_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_alu_result = '0;
    case (bus.control_o_E)
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      ALU_SLT: w_alu_result = {{(DAT_WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero      = (w_alu_result == '0);
  assign bus.PCSrc_E = bus.Branch_E & w_zero;

  // Fit the immediate to the PC width: truncate when wider, sign-extend when narrower.
  generate
    if (DAT_WIDTH >= ADDR_WIDTH) begin : g_imm_trunc
      assign w_imm_addr = bus.ImmExt_E[ADDR_WIDTH-1:0];
    end else begin : g_imm_sext
      assign w_imm_addr = {{(ADDR_WIDTH-DAT_WIDTH){bus.ImmExt_E[DAT_WIDTH-1]}}, bus.ImmExt_E};
    end
  endgenerate

  assign bus.PC_Target_E = bus.PC_E + w_imm_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: rst_n sits in the sensitivity list, clearing the register immediately without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite_m   <= 1'b0;
      r_memwrite_m   <= 1'b0;
      r_memread_m    <= 1'b0;
      r_memtoreg_m   <= 1'b0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_rd_m         <= 5'd0;
      r_pc_4m        <= '0;
    end else begin
      r_regwrite_m   <= bus.RegWrite_E;
      r_memwrite_m   <= bus.MemWrite_E;
      r_memread_m    <= bus.MemRead_E;
      r_memtoreg_m   <= bus.MemtoReg_E;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_fwd_b;
      r_rd_m         <= bus.rd_E;
      r_pc_4m        <= bus.PC_4E;
    end
  end

  assign bus.RegWrite_M  = r_regwrite_m;
  assign bus.MemWrite_M  = r_memwrite_m;
  assign bus.MemRead_M   = r_memread_m;
  assign bus.MemtoReg_M  = r_memtoreg_m;
  assign bus.ALUResult_M = r_alu_result_m;
  assign bus.WriteData_M = r_write_data_m;
  assign bus.rd_M        = r_rd_m;
  assign bus.PC_4M       = r_pc_4m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed hazard/branch/reset scenarios plus
// randomized instruction streams compared against a behavioural pipeline model.
module tb_execute_stage;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;

  execute_stage_if #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  execute_stage #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of the architectural contents of the EX/MEM register.
  logic          m_regwrite, m_memwrite, m_memread, m_memtoreg;
  logic [DW-1:0] m_alu, m_wd;
  logic [4:0]    m_rd;
  logic [AW-1:0] m_pc4;

  typedef struct {
    logic          pcsrc;
    logic [AW-1:0] tgt;
    logic          regwrite, memwrite, memread, memtoreg;
    logic [DW-1:0] alu, wd;
    logic [4:0]    rd;
    logic [AW-1:0] pc4;
    logic          bubble;
  } exp_t;

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return DW'(sa + sb);
      4'b0110: return DW'(sa - sb);
      4'b0111: return (sa < sb) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  // Register value seen by the instruction in EX: the newest in-flight write wins.
  function automatic logic [DW-1:0] ref_operand(input logic [4:0] rs, input logic [DW-1:0] rdata);
    if (rs == 5'd0) return rdata;
    if (m_regwrite && m_rd == rs) return m_alu;
    if (bus.RegWrite_W && bus.rd_W == rs) return bus.Result_W;
    return rdata;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [DW-1:0] a, fb, b;
    a  = ref_operand(bus.rs1_E, bus.rdata1_E);
    fb = ref_operand(bus.rs2_E, bus.rdata2_E);
    b  = bus.ALUSrc_E ? bus.ImmExt_E : fb;
    e.alu      = ref_alu(bus.control_o_E, a, b);
    e.wd       = fb;
    e.pcsrc    = bus.Branch_E && (e.alu == 0);
    e.tgt      = AW'(bus.PC_E + bus.ImmExt_E);
    e.regwrite = bus.RegWrite_E;
    e.memwrite = bus.MemWrite_E;
    e.memread  = bus.MemRead_E;
    e.memtoreg = bus.MemtoReg_E;
    e.rd       = bus.rd_E;
    e.pc4      = bus.PC_4E;
    e.bubble   = !(bus.RegWrite_E || bus.ALUSrc_E || bus.MemWrite_E || bus.MemRead_E ||
                   bus.Branch_E || bus.MemtoReg_E);
    return e;
  endfunction

  function automatic void commit(input exp_t e);
    m_regwrite = e.regwrite;
    m_memwrite = e.memwrite;
    m_memread  = e.memread;
    m_memtoreg = e.memtoreg;
    m_alu      = e.alu;
    m_wd       = e.wd;
    m_rd       = e.rd;
    m_pc4      = e.pc4;
  endfunction

  function automatic void model_reset();
    m_regwrite = 0; m_memwrite = 0; m_memread = 0; m_memtoreg = 0;
    m_alu = '0; m_wd = '0; m_rd = '0; m_pc4 = '0;
  endfunction

  task automatic set_idle();
    bus.RegWrite_E = 0; bus.ALUSrc_E = 0; bus.MemWrite_E = 0; bus.MemRead_E = 0;
    bus.Branch_E = 0; bus.MemtoReg_E = 0; bus.control_o_E = 4'b0010;
    bus.ImmExt_E = '0; bus.rdata1_E = '0; bus.rdata2_E = '0;
    bus.rs1_E = 0; bus.rs2_E = 0; bus.rd_E = 0; bus.PC_E = '0; bus.PC_4E = '0;
    bus.RegWrite_W = 0; bus.rd_W = 0; bus.Result_W = '0;
  endtask

  // Presents an ALU instruction writing rd and clocks it into EX/MEM.
  task automatic issue_alu(input logic [4:0] rd, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    exp_t e;
    @(negedge clk);
    set_idle();
    bus.RegWrite_E = 1; bus.rd_E = rd; bus.rdata1_E = v1; bus.rdata2_E = v2;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    bus.RegWrite_E = 1; bus.MemWrite_E = 1; bus.MemRead_E = 1; bus.MemtoReg_E = 1;
    bus.rdata1_E = 32'h1234; bus.rdata2_E = 32'h99; bus.rd_E = 7; bus.PC_4E = 32'h40;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.RegWrite_M, bus.MemWrite_M, bus.MemRead_M, bus.MemtoReg_M, bus.ALUResult_M,
         bus.WriteData_M, bus.rd_M, bus.PC_4M} !== '0) begin
      failures++;
      $display("FAIL reset_state: M outputs not all zero (alu=%h wd=%h rd=%0d pc4=%h) expected 0",
               bus.ALUResult_M, bus.WriteData_M, bus.rd_M, bus.PC_4M);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_no_hazard();
    exp_t e;
    set_idle();
    bus.RegWrite_E = 1; bus.rd_E = 3; bus.rs1_E = 1; bus.rs2_E = 2;
    bus.rdata1_E = 5; bus.rdata2_E = 7; bus.PC_4E = 32'h104;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.ALUResult_M !== 32'd12) begin
      failures++; $display("FAIL no_hazard_alu: got %0d expected 12", bus.ALUResult_M);
    end
    checks++;
    if (bus.WriteData_M !== 32'd7) begin
      failures++; $display("FAIL no_hazard_wd: got %0d expected 7", bus.WriteData_M);
    end
    checks++;
    if (bus.rd_M !== 5'd3 || bus.RegWrite_M !== 1'b1 || bus.PC_4M !== 32'h104) begin
      failures++;
      $display("FAIL no_hazard_ctl: rd=%0d rw=%0b pc4=%h expected rd=3 rw=1 pc4=104",
               bus.rd_M, bus.RegWrite_M, bus.PC_4M);
    end
  endtask

  // Relies on test_no_hazard leaving rd_M=3, ALUResult_M=12.
  task automatic test_mem_forward();
    exp_t e;
    @(negedge clk);
    set_idle();
    bus.RegWrite_E = 1; bus.ALUSrc_E = 1; bus.ImmExt_E = 1; bus.rd_E = 4;
    bus.rs1_E = 3; bus.rdata1_E = 0; bus.rs2_E = 5; bus.rdata2_E = 32'h55;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.ALUResult_M !== 32'd13) begin
      failures++; $display("FAIL mem_forward_alu: got %0d expected 13", bus.ALUResult_M);
    end
    checks++;
    if (bus.WriteData_M !== 32'h55) begin
      failures++; $display("FAIL mem_forward_store_data: got %h expected 55", bus.WriteData_M);
    end
  endtask

  task automatic test_double_hazard();
    exp_t e;
    issue_alu(5'd3, 32'd20, 32'd0);
    @(negedge clk);
    set_idle();
    bus.RegWrite_E = 1; bus.rd_E = 6;
    bus.RegWrite_W = 1; bus.rd_W = 3; bus.Result_W = 99;
    bus.rs1_E = 3; bus.rs2_E = 0; bus.rdata2_E = 0;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.ALUResult_M !== 32'd20) begin
      failures++; $display("FAIL double_hazard_mem_wins: got %0d expected 20", bus.ALUResult_M);
    end
    // rd_M is now 6, so only WB matches register 3.
    @(negedge clk);
    bus.rd_E = 8; bus.rs2_E = 3; bus.rdata2_E = 32'd1;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.ALUResult_M !== 32'd198 || bus.WriteData_M !== 32'd99) begin
      failures++;
      $display("FAIL wb_forward: alu=%0d wd=%0d expected alu=198 wd=99",
               bus.ALUResult_M, bus.WriteData_M);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    @(negedge clk);
    set_idle();
    bus.Branch_E = 1; bus.control_o_E = 4'b0110; bus.rs1_E = 10; bus.rs2_E = 11;
    bus.rdata1_E = 9; bus.rdata2_E = 9; bus.PC_E = 32'h100; bus.ImmExt_E = 32'hFFFF_FFF0;
    bus.rd_E = 9;
    #1;
    checks++;
    if (bus.PCSrc_E !== 1'b1 || bus.PC_Target_E !== 32'h0000_00F0) begin
      failures++;
      $display("FAIL beq_taken: pcsrc=%0b tgt=%h expected pcsrc=1 tgt=000000f0",
               bus.PCSrc_E, bus.PC_Target_E);
    end
    bus.rdata2_E = 8;
    #1;
    checks++;
    if (bus.PCSrc_E !== 1'b0) begin
      failures++; $display("FAIL beq_not_taken: pcsrc=%0b expected 0", bus.PCSrc_E);
    end
    bus.rdata2_E = 9; bus.Branch_E = 0;
    #1;
    checks++;
    if (bus.PCSrc_E !== 1'b0 || bus.PC_Target_E !== 32'h0000_00F0) begin
      failures++;
      $display("FAIL no_branch_zero: pcsrc=%0b tgt=%h expected pcsrc=0 tgt=000000f0",
               bus.PCSrc_E, bus.PC_Target_E);
    end
    bus.Branch_E = 1;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.rd_M !== 5'd9 || bus.RegWrite_M !== 1'b0 || bus.MemWrite_M !== 1'b0) begin
      failures++;
      $display("FAIL branch_to_mem: rd=%0d rw=%0b mw=%0b expected rd=9 rw=0 mw=0",
               bus.rd_M, bus.RegWrite_M, bus.MemWrite_M);
    end
  endtask

  task automatic test_x0_guard();
    exp_t e;
    issue_alu(5'd0, 32'd55, 32'd0);
    checks++;
    if (bus.ALUResult_M !== 32'd55 || bus.rd_M !== 5'd0) begin
      failures++;
      $display("FAIL x0_setup: alu=%0d rd=%0d expected alu=55 rd=0", bus.ALUResult_M, bus.rd_M);
    end
    @(negedge clk);
    set_idle();
    bus.RegWrite_E = 1; bus.rd_E = 2;
    bus.RegWrite_W = 1; bus.rd_W = 0; bus.Result_W = 77;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.ALUResult_M !== 32'd0 || bus.WriteData_M !== 32'd0) begin
      failures++;
      $display("FAIL x0_guard: alu=%0d wd=%0d expected 0/0", bus.ALUResult_M, bus.WriteData_M);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    set_idle();
    bus.RegWrite_E = 1; bus.MemWrite_E = 1; bus.MemRead_E = 1; bus.MemtoReg_E = 1;
    bus.rd_E = 5; bus.rdata1_E = 32'hA5; bus.rdata2_E = 32'h11; bus.PC_4E = 32'h200;
    #1 e = predict();
    @(posedge clk); #1 commit(e);
    checks++;
    if (bus.RegWrite_M !== 1'b1 || bus.ALUResult_M !== 32'hB6 || bus.PC_4M !== 32'h200) begin
      failures++;
      $display("FAIL async_reset_setup: rw=%0b alu=%h pc4=%h expected rw=1 alu=b6 pc4=200",
               bus.RegWrite_M, bus.ALUResult_M, bus.PC_4M);
    end
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    checks++;
    if ({bus.RegWrite_M, bus.MemWrite_M, bus.MemRead_M, bus.MemtoReg_M, bus.ALUResult_M,
         bus.WriteData_M, bus.rd_M, bus.PC_4M} !== '0) begin
      failures++;
      $display("FAIL async_reset_midcycle: M outputs nonzero (alu=%h rd=%0d) expected 0",
               bus.ALUResult_M, bus.rd_M);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.RegWrite_M, bus.ALUResult_M, bus.rd_M, bus.PC_4M} !== '0) begin
      failures++;
      $display("FAIL async_reset_held: M outputs nonzero across edge (alu=%h) expected 0",
               bus.ALUResult_M);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    exp_t e;
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0000};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.RegWrite_E  = 1'($urandom);
      bus.ALUSrc_E    = 1'($urandom);
      bus.MemWrite_E  = 1'($urandom);
      bus.MemRead_E   = 1'($urandom);
      bus.Branch_E    = 1'($urandom);
      bus.MemtoReg_E  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.RegWrite_E = 0; bus.ALUSrc_E = 0; bus.MemWrite_E = 0;
        bus.MemRead_E = 0; bus.Branch_E = 0; bus.MemtoReg_E = 0;
      end
      ops[5] = 4'($urandom);
      bus.control_o_E = ops[$urandom_range(0, 5)];
      bus.ImmExt_E = ($urandom_range(0, 1) == 1) ? $urandom : DW'($signed(12'($urandom)));
      bus.rdata1_E = $urandom;
      bus.rdata2_E = ($urandom_range(0, 2) == 0) ? bus.rdata1_E : $urandom;
      bus.rs1_E = 5'($urandom_range(0, 3));
      bus.rs2_E = 5'($urandom_range(0, 3));
      bus.rd_E  = 5'($urandom_range(0, 3));
      bus.PC_E  = $urandom;
      bus.PC_4E = bus.PC_E + 4;
      bus.RegWrite_W = 1'($urandom);
      bus.rd_W = 5'($urandom_range(0, 3));
      bus.Result_W = $urandom;
      #1 e = predict();
      checks++;
      if (bus.PCSrc_E !== e.pcsrc || bus.PC_Target_E !== e.tgt) begin
        failures++;
        $display("FAIL rand_branch[%0d]: pcsrc=%0b tgt=%h expected pcsrc=%0b tgt=%h",
                 i, bus.PCSrc_E, bus.PC_Target_E, e.pcsrc, e.tgt);
      end
      @(posedge clk); #1 commit(e);
      checks++;
      if ({bus.RegWrite_M, bus.MemWrite_M, bus.MemRead_M, bus.MemtoReg_M} !==
          {e.regwrite, e.memwrite, e.memread, e.memtoreg}) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: got %b%b%b%b expected %b%b%b%b", i, bus.RegWrite_M,
                 bus.MemWrite_M, bus.MemRead_M, bus.MemtoReg_M,
                 e.regwrite, e.memwrite, e.memread, e.memtoreg);
      end
      if (!e.bubble) begin
        checks++;
        if (bus.ALUResult_M !== e.alu || bus.WriteData_M !== e.wd ||
            bus.rd_M !== e.rd || bus.PC_4M !== e.pc4) begin
          failures++;
          $display("FAIL rand_data[%0d]: alu=%h wd=%h rd=%0d pc4=%h expected alu=%h wd=%h rd=%0d pc4=%h",
                   i, bus.ALUResult_M, bus.WriteData_M, bus.rd_M, bus.PC_4M,
                   e.alu, e.wd, e.rd, e.pc4);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_hazard();
    test_mem_forward();
    test_double_hazard();
    test_branch();
    test_x0_guard();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 DAT_WIDTH, default 32, datapath width.
REQ-002 ADDR_WIDTH, default 32, PC width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E  input  1 each  ID/EX control bits.
REQ-006 control_o_E  input  4  ALU operation code.
REQ-007 ImmExt_E  input  DAT_WIDTH  sign-extended immediate, byte offset for branches.
REQ-008 rdata1_E  input  DAT_WIDTH  register operand 1 from ID/EX.
REQ-009 rdata2_E  input  DAT_WIDTH  register operand 2 from ID/EX.
REQ-010 rs1_E  input  5  source register 1 index.
REQ-011 rs2_E  input  5  source register 2 index.
REQ-012 rd_E  input  5  destination register index.
REQ-013 PC_E  input  ADDR_WIDTH  PC of the instruction in EX.
REQ-014 PC_4E  input  ADDR_WIDTH  PC+4 of the instruction in EX.
REQ-015 RegWrite_W  input  1  writeback-stage write enable.
REQ-016 rd_W  input  5  writeback-stage destination index.
REQ-017 Result_W  input  DAT_WIDTH  writeback-stage result.
REQ-018 PCSrc_E  output  1  branch taken, combinational.
REQ-019 PC_Target_E  output  ADDR_WIDTH  branch target, combinational.
REQ-020 RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M  output  1 each  registered EX/MEM control bits.
REQ-021 ALUResult_M  output  DAT_WIDTH  registered ALU result.
REQ-022 WriteData_M  output  DAT_WIDTH  registered store data.
REQ-023 rd_M  output  5  registered destination index.
REQ-024 PC_4M  output  ADDR_WIDTH  registered PC+4.

Function
REQ-025 Operand A SHALL be selected as follows, in priority order:
- ALUResult_M if RegWrite_M=1, rd_M!=0 and rd_M==rs1_E.
- Otherwise Result_W if RegWrite_W=1, rd_W!=0 and rd_W==rs1_E.
- Otherwise rdata1_E.
REQ-026 The forwarded B value SHALL use the same rule with rs2_E and rdata2_E; the MEM source always wins over the WB source when both match.
REQ-027 Index 0 SHALL never forward.
REQ-028 Load-use hazards are resolved upstream by a one-bubble stall, so load data only ever arrives via Result_W.
REQ-029 SrcB SHALL be ImmExt_E when ALUSrc_E=1; otherwise it is the forwarded B value.
REQ-030 ALU operations by control_o_E: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B), 0111 SLT (signed, result 1/0); all other codes give result 0.
REQ-031 ADD and SUB SHALL wrap modulo 2^DAT_WIDTH, with no overflow flag.
REQ-032 Zero SHALL be 1 when the ALU result is 0; PCSrc_E = Branch_E AND Zero, valid in the same cycle.
REQ-033 PC_Target_E SHALL equal PC_E + ImmExt_E modulo 2^ADDR_WIDTH and is driven regardless of Branch_E.
REQ-034 The EX/MEM register SHALL capture every rising edge with no enable and no flush; latency is 1 cycle.
REQ-035 On capture: the four control bits are taken from the _E inputs, ALUResult_M from the ALU, WriteData_M from the forwarded B value (never the immediate), rd_M from rd_E and PC_4M from PC_4E.
REQ-036 A bubble (all _E control bits 0) SHALL propagate as all-zero M control bits; its data fields are don't-care.
REQ-037 A taken branch in EX SHALL itself proceed to MEM; squashing younger instructions is upstream's job.

Reset
REQ-038 While rst_n=0, all EX/MEM outputs SHALL be 0 immediately, independent of clk, including mid-operation.
REQ-039 The first capture after rst_n deasserts SHALL occur on the next rising edge.

Verification
REQ-040 No hazard: rdata1_E=5, rdata2_E=7, control 0010, ALUSrc_E=0 -> after one edge ALUResult_M=12, WriteData_M=7.
REQ-041 MEM forward: RegWrite_M=1, rd_M=3, ALUResult_M=12; next instruction rs1_E=3, rdata1_E=0, ALUSrc_E=1, ImmExt_E=1, ADD -> ALUResult_M=13.
REQ-042 Double hazard: rd_M=rd_W=3, both write enables 1, ALUResult_M=20, Result_W=99, rs1_E=3, rs2_E=0, rdata2_E=0, ADD -> result 20.
REQ-043 beq: Branch_E=1, SUB, operands 9/9, PC_E=0x100, ImmExt_E=0xFFFFFFF0 -> PCSrc_E=1 and PC_Target_E=0xF0 in the same cycle; with operands 9/8 -> PCSrc_E=0.
REQ-044 x0 guard: RegWrite_M=1, rd_M=0, rs1_E=0, ALUResult_M=55, rdata1_E=0, rdata2_E=0, ADD -> result 0.
REQ-045 Async reset: pull rst_n low between edges with non-zero M outputs -> all M outputs read 0 before the next edge.
